// File: rtl/xbar_bridge_pkg.sv
// rtl/xbar_bridge_pkg.sv - shared response record and widths for the bridge response path
package xbar_bridge_pkg;

    localparam int RESP_DATA_W = 32;
    localparam int RESP_AUX_W  = 8;
    localparam int RESP_TAG_W  = RESP_DATA_W / 8;

    typedef struct packed {
        logic [RESP_DATA_W-1:0] rdata;
        logic [RESP_TAG_W-1:0]  rtag;
        logic                   opc;
        logic [RESP_AUX_W-1:0]  aux;
    } resp_t;

endpackage

// File: rtl/resp_fifo_bridge.sv
// rtl/resp_fifo_bridge.sv - DEPTH x resp_t FIFO with a registered head entry
module resp_fifo_bridge
    import xbar_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  resp_t din,
    input  logic  pop,
    output logic  full,
    output logic  head_valid,
    output resp_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    resp_t          mem [DEPTH];
    logic  [PW-1:0] wr_ptr, rd_ptr;
    logic  [PW-1:0] wr_ptr_n, rd_ptr_n;
    resp_t          head_q, head_n;
    logic           valid_q;

    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_ptr_n   = wr_ptr + PW'(push);
    assign rd_ptr_n   = rd_ptr + PW'(pop);
    assign head_valid = valid_q;
    assign head       = head_q;

    // The next head is either the entry being written this cycle (it lands in the
    // slot the read pointer moves onto) or an entry already resident in storage.
    always_comb begin
        head_n = head_q;
        if (wr_ptr_n != rd_ptr_n) begin
            if (push && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) begin
                head_n = din;
            end else begin
                head_n = mem[rd_ptr_n[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            head_q  <= head_n;
            valid_q <= (wr_ptr_n != rd_ptr_n);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/resp_buffer_bridge.sv
// rtl/resp_buffer_bridge.sv - per-initiator response buffer with outstanding-credit request gating
module resp_buffer_bridge
    import xbar_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = RESP_DATA_W,
    parameter int AUX_WIDTH  = RESP_AUX_W,
    parameter int TAG_WIDTH  = DATA_WIDTH / 8,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_req_i,
    output logic                       data_gnt_o,
    output logic                       data_req_o,
    input  logic                       data_gnt_i,
    input  logic                       data_r_valid_i,
    input  logic [DATA_WIDTH-1:0]      data_r_rdata_i,
    input  logic [TAG_WIDTH-1:0]       data_r_rtag_i,
    input  logic                       data_r_opc_i,
    input  logic [AUX_WIDTH-1:0]       data_r_aux_i,
    output logic                       data_r_valid_o,
    input  logic                       data_r_ready_i,
    output logic [DATA_WIDTH-1:0]      data_r_rdata_o,
    output logic [TAG_WIDTH-1:0]       data_r_rtag_o,
    output logic                       data_r_opc_o,
    output logic [AUX_WIDTH-1:0]       data_r_aux_o,
    output logic [$clog2(DEPTH):0]     outstanding_o,
    output logic                       overflow_o
);

    localparam int OW = $clog2(DEPTH) + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    logic [OW-1:0] outstanding_q;
    logic          overflow_q;
    logic          credit_ok;
    logic          issue, pop, push;
    logic          fifo_full;
    logic          head_valid;
    resp_t         din, head;

    // Credit is derived from registered state only, so gnt_i never reaches req_o.
    assign credit_ok  = (outstanding_q < DEPTH_C);
    assign data_req_o = data_req_i & credit_ok;
    assign data_gnt_o = data_gnt_i & credit_ok;

    assign issue = data_req_o & data_gnt_i;
    assign pop   = head_valid & data_r_ready_i;
    assign push  = data_r_valid_i & (~fifo_full | pop);

    assign din.rdata = data_r_rdata_i;
    assign din.rtag  = data_r_rtag_i;
    assign din.opc   = data_r_opc_i;
    assign din.aux   = data_r_aux_i;

    resp_fifo_bridge #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .din        (din),
        .pop        (pop),
        .full       (fifo_full),
        .head_valid (head_valid),
        .head       (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            case ({issue, pop})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   if (outstanding_q != '0) outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
            if (data_r_valid_i && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign data_r_valid_o = head_valid;
    assign data_r_rdata_o = head.rdata;
    assign data_r_rtag_o  = head.rtag;
    assign data_r_opc_o   = head.opc;
    assign data_r_aux_o   = head.aux;
    assign outstanding_o  = outstanding_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_resp_buffer_bridge.sv
// tb/tb_resp_buffer_bridge.sv - directed self-checking bench for resp_buffer_bridge
module tb_resp_buffer_bridge;

    logic        clk;
    logic        rst;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_r_valid_i;
    logic [31:0] data_r_rdata_i;
    logic [3:0]  data_r_rtag_i;
    logic        data_r_opc_i;
    logic [7:0]  data_r_aux_i;
    logic        data_r_valid_o;
    logic        data_r_ready_i;
    logic [31:0] data_r_rdata_o;
    logic [3:0]  data_r_rtag_o;
    logic        data_r_opc_o;
    logic [7:0]  data_r_aux_o;
    logic [2:0]  outstanding_o;
    logic        overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    resp_buffer_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_r_valid_i (data_r_valid_i),
        .data_r_rdata_i (data_r_rdata_i),
        .data_r_rtag_i  (data_r_rtag_i),
        .data_r_opc_i   (data_r_opc_i),
        .data_r_aux_i   (data_r_aux_i),
        .data_r_valid_o (data_r_valid_o),
        .data_r_ready_i (data_r_ready_i),
        .data_r_rdata_o (data_r_rdata_o),
        .data_r_rtag_o  (data_r_rtag_o),
        .data_r_opc_o   (data_r_opc_o),
        .data_r_aux_o   (data_r_aux_o),
        .outstanding_o  (outstanding_o),
        .overflow_o     (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic issue_with_resp(input logic [31:0] d);
        data_req_i     = 1'b1;
        data_gnt_i     = 1'b1;
        data_r_valid_i = 1'b1;
        data_r_rdata_i = d;
        step();
        data_req_i     = 1'b0;
        data_gnt_i     = 1'b0;
        data_r_valid_i = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        data_req_i     = 1'b0;
        data_gnt_i     = 1'b0;
        data_r_valid_i = 1'b0;
        data_r_rdata_i = '0;
        data_r_rtag_i  = '0;
        data_r_opc_i   = 1'b0;
        data_r_aux_i   = '0;
        data_r_ready_i = 1'b0;
        repeat (2) step();

        check("rst_valid", data_r_valid_o, 0);
        check("rst_outst", outstanding_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_rdata", data_r_rdata_o, 0);
        rst = 1'b0;

        // single read
        data_req_i = 1'b1;
        data_gnt_i = 1'b1;
        #1;
        check("rd_req_o", data_req_o, 1);
        check("rd_gnt_o", data_gnt_o, 1);
        step();
        data_req_i = 1'b0;
        data_gnt_i = 1'b0;
        check("rd_outst1", outstanding_o, 1);
        step();
        step();
        data_r_valid_i = 1'b1;
        data_r_rdata_i = 32'hDEADBEEF;
        data_r_rtag_i  = 4'hF;
        data_r_aux_i   = 8'h3C;
        #1;
        check("rd_no_bypass", data_r_valid_o, 0);
        step();
        data_r_valid_i = 1'b0;
        data_r_rtag_i  = 4'h0;
        data_r_aux_i   = 8'h00;
        check("rd_valid", data_r_valid_o, 1);
        check("rd_rdata", data_r_rdata_o, 32'hDEADBEEF);
        check("rd_rtag", data_r_rtag_o, 4'hF);
        check("rd_aux", data_r_aux_o, 8'h3C);
        data_r_ready_i = 1'b1;
        step();
        data_r_ready_i = 1'b0;
        check("rd_outst0", outstanding_o, 0);
        check("rd_empty", data_r_valid_o, 0);

        // credit stall
        for (int k = 0; k < 4; k++) issue_with_resp(32'hA0 + k);
        data_req_i = 1'b1;
        data_gnt_i = 1'b1;
        #1;
        check("cs_outst4", outstanding_o, 4);
        check("cs_req_o", data_req_o, 0);
        check("cs_gnt_o", data_gnt_o, 0);
        check("cs_head", data_r_rdata_o, 32'hA0);
        data_r_ready_i = 1'b1;
        step();
        data_r_ready_i = 1'b0;
        #1;
        check("cs_outst3", outstanding_o, 3);
        check("cs_req_o_back", data_req_o, 1);
        check("cs_gnt_o_back", data_gnt_o, 1);
        step();
        data_req_i = 1'b0;
        data_gnt_i = 1'b0;
        check("cs_outst4b", outstanding_o, 4);
        data_r_valid_i = 1'b1;
        data_r_rdata_i = 32'hA4;
        step();
        data_r_valid_i = 1'b0;
        check("cs_head_a1", data_r_rdata_o, 32'hA1);

        // full + simultaneous push/pop
        data_r_valid_i = 1'b1;
        data_r_rdata_i = 32'h55;
        data_r_ready_i = 1'b1;
        step();
        data_r_valid_i = 1'b0;
        data_r_ready_i = 1'b0;
        check("fp_ovf", overflow_o, 0);
        check("fp_outst", outstanding_o, 3);
        data_r_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_d;
            exp_d = (k == 3) ? 32'h55 : 32'hA2 + k;
            check("fp_valid", data_r_valid_o, 1);
            check("fp_order", data_r_rdata_o, exp_d);
            step();
        end
        data_r_ready_i = 1'b0;
        check("fp_drained", data_r_valid_o, 0);
        reset_dut();

        // overflow
        for (int k = 0; k < 4; k++) issue_with_resp(32'hB0 + k);
        data_r_valid_i = 1'b1;
        data_r_rdata_i = 32'hEE;
        step();
        data_r_valid_i = 1'b0;
        check("ov_flag", overflow_o, 1);
        check("ov_outst", outstanding_o, 4);
        data_r_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("ov_order", data_r_rdata_o, 32'hB0 + k);
            step();
        end
        data_r_ready_i = 1'b0;
        check("ov_drained", data_r_valid_o, 0);
        check("ov_sticky", overflow_o, 1);
        check("ov_outst0", outstanding_o, 0);
        reset_dut();

        // back-pressure
        for (int k = 1; k <= 3; k++) issue_with_resp(k);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", data_r_valid_o, 1);
            check("bp_head", data_r_rdata_o, 1);
            step();
        end
        data_r_ready_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            check("bp_valid_pop", data_r_valid_o, 1);
            check("bp_order", data_r_rdata_o, k);
            step();
        end
        data_r_ready_i = 1'b0;
        check("bp_empty", data_r_valid_o, 0);

        // async reset mid-cycle
        issue_with_resp(32'hC0);
        issue_with_resp(32'hC1);
        check("ar_pre_outst", outstanding_o, 2);
        rst = 1'b1;
        #1;
        check("ar_valid", data_r_valid_o, 0);
        check("ar_outst", outstanding_o, 0);
        step();
        rst = 1'b0;
        step();
        check("ar_post_valid", data_r_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
